// File: rtl/alu_seq_if.sv
// Operation request / result handshake bundle for alu_seq.
// The master issues ops and consumes results; the slave is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [6:0]       op;
    logic             carry_in;
    logic             decimal_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] hold_reg;
    logic             carry_out;
    logic             overflow;
    logic             half_carry;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, reg_a, reg_b, op, carry_in, decimal_mode, out_ready,
        input  in_ready, out_valid, hold_reg, carry_out, overflow, half_carry, zero, negative
    );

    modport slave (
        input  in_valid, reg_a, reg_b, op, carry_in, decimal_mode, out_ready,
        output in_ready, out_valid, hold_reg, carry_out, overflow, half_carry, zero, negative
    );
endinterface

// File: rtl/alu_seq.sv
// Registered 6502-style ALU with nibble-serial BCD add/subtract.
// Latency: binary ops valid from the accept edge; decimal ops after WIDTH/4 more edges.
// Backpressure: result held in DONE until out_ready; a new op is taken on the consuming edge.
module alu_seq #(
    parameter int WIDTH      = 8,
    parameter bit DECIMAL_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_seq_if.slave    bus
);
    localparam int N    = WIDTH / 4;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADJ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [6:0] OP_SUM = 7'b1000000;
    localparam logic [6:0] OP_SUB = 7'b0100000;
    localparam logic [6:0] OP_AND = 7'b0010000;
    localparam logic [6:0] OP_OR  = 7'b0001000;
    localparam logic [6:0] OP_EOR = 7'b0000100;
    localparam logic [6:0] OP_SR  = 7'b0000010;
    localparam logic [6:0] OP_ROR = 7'b0000001;

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sub_q;
    logic             c_q;
    logic [WIDTH-1:0] hold_q;
    logic             cf_q;
    logic             vf_q;
    logic             hf_q;
    logic             zf_q;
    logic             nf_q;

    logic             accept;
    logic             is_sub;
    logic             go_dec;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_full;
    logic [4:0]       low_sum;
    logic             add_v;
    logic [WIDTH-1:0] bin_res;
    logic             bin_c;
    logic             bin_v;
    logic             bin_h;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       raw;
    logic [3:0]       d_nib;
    logic             c_next;
    logic [WIDTH-1:0] dec_res;
    logic             last_nib;

    assign bus.in_ready   = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
    assign bus.out_valid  = (state == S_DONE);
    assign bus.hold_reg   = hold_q;
    assign bus.carry_out  = cf_q;
    assign bus.overflow   = vf_q;
    assign bus.half_carry = hf_q;
    assign bus.zero       = zf_q;
    assign bus.negative   = nf_q;

    assign accept = bus.in_valid && bus.in_ready;

    // Single-cycle result for every op; also supplies the overflow flag for decimal ops.
    always_comb begin
        is_sub   = (bus.op == OP_SUB);
        b_eff    = is_sub ? ~bus.reg_b : bus.reg_b;
        sum_full = {1'b0, bus.reg_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.carry_in};
        low_sum  = {1'b0, bus.reg_a[3:0]} + {1'b0, b_eff[3:0]} + {4'b0000, bus.carry_in};
        add_v    = (bus.reg_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                   (sum_full[WIDTH-1] != bus.reg_a[WIDTH-1]);
        bin_res  = bus.reg_a;
        bin_c    = bus.carry_in;
        bin_v    = 1'b0;
        bin_h    = 1'b0;
        case (bus.op)
            OP_SUM, OP_SUB: begin
                bin_res = sum_full[WIDTH-1:0];
                bin_c   = sum_full[WIDTH];
                bin_v   = add_v;
                bin_h   = low_sum[4];
            end
            OP_AND: bin_res = bus.reg_a & bus.reg_b;
            OP_OR:  bin_res = bus.reg_a | bus.reg_b;
            OP_EOR: bin_res = bus.reg_a ^ bus.reg_b;
            OP_SR: begin
                bin_res = {1'b0, bus.reg_a[WIDTH-1:1]};
                bin_c   = bus.reg_a[0];
            end
            OP_ROR: begin
                bin_res = {bus.carry_in, bus.reg_a[WIDTH-1:1]};
                bin_c   = bus.reg_a[0];
            end
            default: ;
        endcase
        go_dec = DECIMAL_EN && bus.decimal_mode && ((bus.op == OP_SUM) || is_sub);
    end

    // One BCD digit per cycle; raw is 5 bits so bit 4 doubles as the borrow sign for SUB.
    always_comb begin
        a_nib  = a_q[int'(idx)*4 +: 4];
        b_nib  = b_q[int'(idx)*4 +: 4];
        raw    = 5'd0;
        d_nib  = 4'd0;
        c_next = 1'b0;
        if (!sub_q) begin
            raw = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, c_q};
            if (raw > 5'd9) begin
                d_nib  = raw[3:0] + 4'd6;
                c_next = 1'b1;
            end else begin
                d_nib  = raw[3:0];
                c_next = 1'b0;
            end
        end else begin
            raw = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, ~c_q};
            if (raw[4]) begin
                d_nib  = raw[3:0] - 4'd6;
                c_next = 1'b0;
            end else begin
                d_nib  = raw[3:0];
                c_next = 1'b1;
            end
        end
        dec_res = hold_q;
        dec_res[int'(idx)*4 +: 4] = d_nib;
        last_nib = (idx == IDXW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sub_q  <= 1'b0;
            c_q    <= 1'b0;
            hold_q <= '0;
            cf_q   <= 1'b0;
            vf_q   <= 1'b0;
            hf_q   <= 1'b0;
            zf_q   <= 1'b0;
            nf_q   <= 1'b0;
        end else if (accept) begin
            if (go_dec) begin
                a_q   <= bus.reg_a;
                b_q   <= bus.reg_b;
                sub_q <= is_sub;
                c_q   <= bus.carry_in;
                idx   <= '0;
                vf_q  <= add_v;
                state <= S_ADJ;
            end else begin
                hold_q <= bin_res;
                cf_q   <= bin_c;
                vf_q   <= bin_v;
                hf_q   <= bin_h;
                zf_q   <= (bin_res == '0);
                nf_q   <= bin_res[WIDTH-1];
                state  <= S_DONE;
            end
        end else if (state == S_ADJ) begin
            hold_q <= dec_res;
            c_q    <= c_next;
            if (idx == '0) begin
                hf_q <= c_next;
            end
            if (last_nib) begin
                cf_q  <= c_next;
                zf_q  <= (dec_res == '0);
                nf_q  <= dec_res[WIDTH-1];
                idx   <= '0;
                state <= S_DONE;
            end else begin
                idx <= idx + IDXW'(1);
            end
        end else if ((state == S_DONE) && bus.out_ready) begin
            state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: binary vector table on WIDTH=8, plus decimal,
// backpressure, reset-abort and WIDTH=16 decimal sequences.
module tb_alu_seq;
    localparam logic [6:0] OP_SUM = 7'b1000000;
    localparam logic [6:0] OP_SUB = 7'b0100000;
    localparam logic [6:0] OP_AND = 7'b0010000;
    localparam logic [6:0] OP_OR  = 7'b0001000;
    localparam logic [6:0] OP_EOR = 7'b0000100;
    localparam logic [6:0] OP_SR  = 7'b0000010;
    localparam logic [6:0] OP_ROR = 7'b0000001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8))  b8();
    alu_seq_if #(.WIDTH(16)) b16();

    alu_seq #(.WIDTH(8),  .DECIMAL_EN(1'b1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    alu_seq #(.WIDTH(16), .DECIMAL_EN(1'b1)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] op;
        logic       cin;
        logic [7:0] res;
        logic [4:0] cvhzn;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] flags8();
        return {b8.carry_out, b8.overflow, b8.half_carry, b8.zero, b8.negative};
    endfunction

    function automatic logic [4:0] flags16();
        return {b16.carry_out, b16.overflow, b16.half_carry, b16.zero, b16.negative};
    endfunction

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic [6:0] op,
                          input logic cin, input logic dec);
        b8.in_valid     = 1'b1;
        b8.reg_a        = a;
        b8.reg_b        = b;
        b8.op           = op;
        b8.carry_in     = cin;
        b8.decimal_mode = dec;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // flags packed as {C, V, H, Z, N}
        tbl[0]  = '{8'h7F, 8'h01, OP_SUM, 1'b0, 8'h80, 5'b01101};
        tbl[1]  = '{8'h00, 8'h01, OP_SUB, 1'b1, 8'hFF, 5'b00001};
        tbl[2]  = '{8'h81, 8'h00, OP_SR,  1'b0, 8'h40, 5'b10000};
        tbl[3]  = '{8'h01, 8'h00, OP_ROR, 1'b1, 8'h80, 5'b10001};
        tbl[4]  = '{8'hF0, 8'h3C, OP_AND, 1'b1, 8'h30, 5'b10000};
        tbl[5]  = '{8'h0F, 8'h80, OP_OR,  1'b0, 8'h8F, 5'b00001};
        tbl[6]  = '{8'hAA, 8'hAA, OP_EOR, 1'b0, 8'h00, 5'b00010};
        tbl[7]  = '{8'hFF, 8'h01, OP_SUM, 1'b0, 8'h00, 5'b10110};
        tbl[8]  = '{8'h50, 8'hF0, OP_SUB, 1'b1, 8'h60, 5'b00100};
        tbl[9]  = '{8'h80, 8'h01, OP_SUB, 1'b1, 8'h7F, 5'b11000};
        tbl[10] = '{8'h00, 8'h55, 7'b0000000, 1'b1, 8'h00, 5'b10010};
        tbl[11] = '{8'h85, 8'h11, 7'b1100000, 1'b0, 8'h85, 5'b00001};

        b8.in_valid = 1'b0;  b8.reg_a = '0;  b8.reg_b = '0;  b8.op = '0;
        b8.carry_in = 1'b0;  b8.decimal_mode = 1'b0;  b8.out_ready = 1'b1;
        b16.in_valid = 1'b0; b16.reg_a = '0; b16.reg_b = '0; b16.op = '0;
        b16.carry_in = 1'b0; b16.decimal_mode = 1'b0; b16.out_ready = 1'b1;

        #2;
        chk("reset out_valid", b8.out_valid, 1'b0);
        chk("reset in_ready", b8.in_ready, 1'b1);
        chk("reset hold_reg", b8.hold_reg, 8'h00);
        chk("reset flags", flags8(), 5'b00000);
        chk("reset w16 in_ready", b16.in_ready, 1'b1);
        #10 rst_n = 1'b1;
        tick();
        chk("post-reset in_ready", b8.in_ready, 1'b1);

        // Back-to-back binary ops, one per cycle
        for (int i = 0; i < 12; i++) begin
            drive8(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].cin, 1'b0);
            #1;
            chk($sformatf("vec%0d in_ready", i), b8.in_ready, 1'b1);
            tick();
            chk($sformatf("vec%0d out_valid", i), b8.out_valid, 1'b1);
            chk($sformatf("vec%0d hold_reg", i), b8.hold_reg, tbl[i].res);
            chk($sformatf("vec%0d flags", i), flags8(), tbl[i].cvhzn);
        end
        b8.in_valid = 1'b0;
        tick();
        chk("idle out_valid", b8.out_valid, 1'b0);

        // Decimal SUM 58+46+1; operands scrambled after accept
        drive8(8'h58, 8'h46, OP_SUM, 1'b1, 1'b1);
        tick();
        b8.in_valid = 1'b0; b8.reg_a = 8'hFF; b8.reg_b = 8'hFF; b8.op = OP_AND;
        chk("dsum E out_valid", b8.out_valid, 1'b0);
        chk("dsum E in_ready", b8.in_ready, 1'b0);
        tick();
        chk("dsum E+1 out_valid", b8.out_valid, 1'b0);
        chk("dsum E+1 in_ready", b8.in_ready, 1'b0);
        tick();
        chk("dsum E+2 out_valid", b8.out_valid, 1'b1);
        chk("dsum hold_reg", b8.hold_reg, 8'h05);
        chk("dsum flags", flags8(), 5'b11100);

        // Decimal SUB accepted on the consuming edge
        drive8(8'h12, 8'h21, OP_SUB, 1'b1, 1'b1);
        tick();
        b8.in_valid = 1'b0;
        chk("dsub E out_valid", b8.out_valid, 1'b0);
        tick();
        chk("dsub E+1 out_valid", b8.out_valid, 1'b0);
        tick();
        chk("dsub out_valid", b8.out_valid, 1'b1);
        chk("dsub hold_reg", b8.hold_reg, 8'h91);
        chk("dsub flags", flags8(), 5'b00101);

        // Backpressure: result must stay put and no new op is taken
        b8.out_ready = 1'b0;
        drive8(8'h01, 8'h02, OP_SUM, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp%0d out_valid", k), b8.out_valid, 1'b1);
            chk($sformatf("bp%0d in_ready", k), b8.in_ready, 1'b0);
            chk($sformatf("bp%0d hold_reg", k), b8.hold_reg, 8'h91);
            chk($sformatf("bp%0d flags", k), flags8(), 5'b00101);
        end
        b8.out_ready = 1'b1;
        #1;
        chk("bp release in_ready", b8.in_ready, 1'b1);
        tick();
        b8.in_valid = 1'b0;
        chk("bp next out_valid", b8.out_valid, 1'b1);
        chk("bp next hold_reg", b8.hold_reg, 8'h03);
        chk("bp next flags", flags8(), 5'b00000);
        tick();

        // WIDTH=16 decimal 9999+0001
        b16.in_valid = 1'b1; b16.reg_a = 16'h9999; b16.reg_b = 16'h0001;
        b16.op = OP_SUM; b16.carry_in = 1'b0; b16.decimal_mode = 1'b1;
        tick();
        b16.in_valid = 1'b0; b16.reg_a = 16'h1234;
        chk("w16 E in_ready", b16.in_ready, 1'b0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk($sformatf("w16 E+%0d in_ready", k), b16.in_ready, 1'b0);
            chk($sformatf("w16 E+%0d out_valid", k), b16.out_valid, 1'b0);
        end
        tick();
        chk("w16 out_valid", b16.out_valid, 1'b1);
        chk("w16 hold_reg", b16.hold_reg, 16'h0000);
        chk("w16 flags", flags16(), 5'b10110);
        tick();

        // Reset while nibble 1 is in flight
        drive8(8'h58, 8'h46, OP_SUM, 1'b1, 1'b1);
        tick();
        b8.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", b8.out_valid, 1'b0);
        chk("abort hold_reg", b8.hold_reg, 8'h00);
        chk("abort flags", flags8(), 5'b00000);
        chk("abort in_ready", b8.in_ready, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        chk("release in_ready", b8.in_ready, 1'b1);
        chk("release out_valid", b8.out_valid, 1'b0);
        drive8(8'h10, 8'h20, OP_SUM, 1'b0, 1'b0);
        tick();
        b8.in_valid = 1'b0;
        chk("after abort out_valid", b8.out_valid, 1'b1);
        chk("after abort hold_reg", b8.hold_reg, 8'h30);
        chk("after abort flags", flags8(), 5'b00000);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
